// File: rtl/matrix.sv
// Streaming Toeplitz-matrix builder: sliding sample window with a registered element read port.
// Define MATRIX_SYMM_EN for symmetric mode (W = N, T[i][j] = w[|i-j|]); default is general mode (W = 2N-1).
module matrix #(
    parameter int N  = 4,
    parameter int DW = 16,
    parameter int AW = (N > 2) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid,
    input  logic [DW-1:0] data,
    input  logic [AW-1:0] rd_row,
    input  logic [AW-1:0] rd_col,
    output logic [DW-1:0] rd_data,
    output logic          mat_valid,
    output logic          mat_update,
    output logic [AW+1:0] sample_cnt
);

`ifdef MATRIX_SYMM_EN
    localparam int W = N;
`else
    localparam int W = 2 * N - 1;
`endif
    localparam int CW = AW + 2;

    // Input handshake: valid-only, no ready. Every edge with valid=1 (and rst=0) accepts data.
    logic [DW-1:0] win [W];
    logic [DW-1:0] elem;
    logic          last_fill;
    int            ri;
    int            ci;
    int            idx;

    // Element select works on the pre-shift window, so a read on a write edge sees old values.
    always_comb begin
        elem = '0;
        ri   = int'(rd_row);
        ci   = int'(rd_col);
`ifdef MATRIX_SYMM_EN
        idx  = (ri >= ci) ? (ri - ci) : (ci - ri);
`else
        idx  = N - 1 + ri - ci;
`endif
        if (ri < N && ci < N) begin
            for (int k = 0; k < W; k++) begin
                if (k == idx) elem = win[k];
            end
        end
    end

    assign last_fill = valid && (sample_cnt == CW'(W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < W; k++) win[k] <= '0;
            rd_data    <= '0;
            sample_cnt <= '0;
            mat_valid  <= 1'b0;
            mat_update <= 1'b0;
        end else begin
            rd_data    <= elem;
            mat_valid  <= mat_valid | last_fill;
            mat_update <= valid & (mat_valid | last_fill);
            if (valid) begin
                for (int k = 0; k < W - 1; k++) win[k] <= win[k+1];
                win[W-1] <= data;
                if (sample_cnt != CW'(W)) sample_cnt <= sample_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_matrix.sv
// Self-checking bench for matrix: reference window model plus a queue of expected read data.
module tb_matrix;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 2;
`ifdef MATRIX_SYMM_EN
    localparam int W = N;
`else
    localparam int W = 2 * N - 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic [DW-1:0] data;
    logic [AW-1:0] rd_row;
    logic [AW-1:0] rd_col;
    logic [DW-1:0] rd_data;
    logic          mat_valid;
    logic          mat_update;
    logic [AW+1:0] sample_cnt;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m[W];
    int            cnt_m;
    bit            mv_m;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    matrix #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .valid(valid), .data(data),
        .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .mat_valid(mat_valid), .mat_update(mat_update), .sample_cnt(sample_cnt)
    );

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] t_model(input int i, input int j);
        if (i >= N || j >= N) return '0;
`ifdef MATRIX_SYMM_EN
        return m[(i >= j) ? (i - j) : (j - i)];
`else
        return m[N - 1 + i - j];
`endif
    endfunction

    task automatic model_clear();
        for (int k = 0; k < W; k++) m[k] = '0;
        cnt_m = 0;
        mv_m  = 1'b0;
    endtask

    task automatic model_accept(input logic [DW-1:0] d);
        for (int k = 0; k < W - 1; k++) m[k] = m[k+1];
        m[W-1] = d;
        if (cnt_m == W - 1) mv_m = 1'b1;
        if (cnt_m < W) cnt_m++;
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset(input int cycles);
        rst   = 1'b1;
        valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // Leaves valid high so consecutive calls form a back-to-back burst.
    task automatic send(input logic [DW-1:0] d);
        valid = 1'b1;
        data  = d;
        @(posedge clk);
        model_accept(d);
        #1;
    endtask

    task automatic drive_read(input int r, input int c, input logic [DW-1:0] e);
        valid  = 1'b0;
        rd_row = AW'(r);
        rd_col = AW'(c);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [DW-1:0] e;
        rst = 1'b1;
        valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mat_valid !== 1'b0 || sample_cnt !== '0 || mat_update !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got mv=%0b cnt=%0d upd=%0b exp 0 0 0", mat_valid, sample_cnt, mat_update);
        end
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                drive_read(i, j, '0);
                e = exp_q.pop_front();
                checks++;
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL reset_read T[%0d][%0d] got %0d exp %0d", i, j, rd_data, e);
                end
            end
        end
    endtask

`ifdef MATRIX_SYMM_EN
    task automatic test_symm();
        int rr[4] = '{0, 0, 3, 1};
        int cc[4] = '{0, 3, 0, 2};
        int ee[4] = '{2, 5, 5, 3};
        logic [DW-1:0] e;
        do_reset(2);
        for (int d = 1; d <= 5; d++) send(DW'(d));
        checks++;
        if (mat_valid !== 1'b1 || sample_cnt !== 4'd4) begin
            errors++;
            $display("FAIL symm_flags got mv=%0b cnt=%0d exp 1 4", mat_valid, sample_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            drive_read(rr[k], cc[k], DW'(ee[k]));
            e = exp_q.pop_front();
            checks++;
            if (rd_data !== e) begin
                errors++;
                $display("FAIL symm_read T[%0d][%0d] got %0d exp %0d", rr[k], cc[k], rd_data, e);
            end
        end
    endtask
`else
    task automatic test_fill();
        int rr[6] = '{3, 0, 0, 1, 2, 3};
        int cc[6] = '{0, 3, 0, 1, 2, 3};
        int ee[6] = '{7, 1, 4, 4, 4, 4};
        logic [DW-1:0] e;
        do_reset(2);
        for (int d = 1; d <= 6; d++) send(DW'(d));
        checks++;
        if (mat_valid !== 1'b0 || sample_cnt !== 4'd6 || mat_update !== 1'b0) begin
            errors++;
            $display("FAIL fill_six got mv=%0b cnt=%0d upd=%0b exp 0 6 0", mat_valid, sample_cnt, mat_update);
        end
        send(16'd7);
        checks++;
        if (mat_valid !== 1'b1 || sample_cnt !== 4'd7 || mat_update !== 1'b1) begin
            errors++;
            $display("FAIL fill_seventh got mv=%0b cnt=%0d upd=%0b exp 1 7 1", mat_valid, sample_cnt, mat_update);
        end
        for (int k = 0; k < 6; k++) begin
            drive_read(rr[k], cc[k], DW'(ee[k]));
            e = exp_q.pop_front();
            checks++;
            if (rd_data !== e) begin
                errors++;
                $display("FAIL fill_read T[%0d][%0d] got %0d exp %0d", rr[k], cc[k], rd_data, e);
            end
            if (k == 0) begin
                checks++;
                if (mat_update !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_pulse_end got %0b exp 0", mat_update);
                end
            end
        end
    endtask

    task automatic test_burst();
        int rr[9] = '{3, 0, 0, 1, 2, 3, 1, 2, 3};
        int cc[9] = '{0, 3, 0, 1, 2, 3, 0, 1, 2};
        int ee[9] = '{21, 15, 18, 18, 18, 18, 19, 19, 19};
        logic [DW-1:0] e;
        do_reset(2);
        for (int d = 1; d <= 21; d++) begin
            send(DW'(d));
            checks++;
            if (mat_update !== (d >= 7) || sample_cnt !== 4'((d < 7) ? d : 7)) begin
                errors++;
                $display("FAIL burst_sample %0d got upd=%0b cnt=%0d exp %0b %0d",
                         d, mat_update, sample_cnt, (d >= 7), (d < 7) ? d : 7);
            end
        end
        valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            checks++;
            if (mat_update !== 1'b0 || mat_valid !== 1'b1) begin
                errors++;
                $display("FAIL burst_idle got upd=%0b mv=%0b exp 0 1", mat_update, mat_valid);
            end
        end
        for (int k = 0; k < 9; k++) begin
            drive_read(rr[k], cc[k], DW'(ee[k]));
            e = exp_q.pop_front();
            checks++;
            if (rd_data !== e) begin
                errors++;
                $display("FAIL burst_read T[%0d][%0d] got %0d exp %0d", rr[k], cc[k], rd_data, e);
            end
        end
    endtask

    task automatic test_simul();
        logic [DW-1:0] e;
        valid  = 1'b1;
        data   = 16'd22;
        rd_row = 2'd2;
        rd_col = 2'd0;
        exp_q.push_back(16'd20);
        @(posedge clk);
        model_accept(16'd22);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (rd_data !== e) begin
            errors++;
            $display("FAIL simul_preshift got %0d exp %0d", rd_data, e);
        end
        drive_read(2, 0, 16'd21);
        e = exp_q.pop_front();
        checks++;
        if (rd_data !== e) begin
            errors++;
            $display("FAIL simul_postshift got %0d exp %0d", rd_data, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] e;
        do_reset(2);
        rd_row = 2'd3;
        rd_col = 2'd0;
        for (int d = 1; d <= 3; d++) send(DW'(d));
        rst  = 1'b1;
        data = 16'd99;
        @(posedge clk);
        #1;
        model_clear();
        checks++;
        if (rd_data !== '0 || sample_cnt !== '0 || mat_valid !== 1'b0 || mat_update !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs got rd=%0d cnt=%0d mv=%0b upd=%0b exp 0 0 0 0",
                     rd_data, sample_cnt, mat_valid, mat_update);
        end
        rst = 1'b0;
        for (int d = 10; d <= 15; d++) send(DW'(d));
        checks++;
        if (mat_valid !== 1'b0 || sample_cnt !== 4'd6) begin
            errors++;
            $display("FAIL midreset_six got mv=%0b cnt=%0d exp 0 6", mat_valid, sample_cnt);
        end
        send(16'd16);
        checks++;
        if (mat_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_refill got mv=%0b exp 1", mat_valid);
        end
        drive_read(0, 3, 16'd10);
        e = exp_q.pop_front();
        checks++;
        if (rd_data !== e) begin
            errors++;
            $display("FAIL midreset_oldest got %0d exp %0d", rd_data, e);
        end
    endtask
`endif

    task automatic test_random();
        logic [DW-1:0] e;
        logic [DW-1:0] d;
        bit            v;
        bit            upd;
        int            r;
        int            c;
        do_reset(2);
        for (int n = 0; n < 80; n++) begin
            v = ($urandom_range(0, 2) != 0);
            d = DW'($urandom_range(0, 65535));
            r = $urandom_range(0, N - 1);
            c = $urandom_range(0, N - 1);
            valid  = v;
            data   = d;
            rd_row = AW'(r);
            rd_col = AW'(c);
            exp_q.push_back(t_model(r, c));
            upd = v && (mv_m || cnt_m == W - 1);
            @(posedge clk);
            if (v) model_accept(d);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (rd_data !== e || mat_update !== upd || mat_valid !== mv_m || sample_cnt !== 4'(cnt_m)) begin
                errors++;
                $display("FAIL random_%0d T[%0d][%0d] got rd=%0d upd=%0b mv=%0b cnt=%0d exp %0d %0b %0b %0d",
                         n, r, c, rd_data, mat_update, mat_valid, sample_cnt, e, upd, mv_m, cnt_m);
            end
        end
        valid = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        valid  = 1'b0;
        data   = '0;
        rd_row = '0;
        rd_col = '0;
        model_clear();
        test_reset();
`ifdef MATRIX_SYMM_EN
        test_symm();
`else
        test_fill();
        test_burst();
        test_simul();
        test_reset_mid();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix.md
Name: matrix

Overview:
- Streaming Toeplitz-matrix builder: accepts 16-bit samples on a valid strobe and keeps a sliding window of the most recent samples.
- Exposes the resulting N x N Toeplitz matrix through a registered element read port.
- Sits between a sample source (ADC/DSP front end) and a consumer such as a correlation/solver engine that fetches matrix elements by row/column address.

Parameters:
- N, 4, matrix dimension (N >= 2)
- DW, 16, sample/element width in bits
- AW, $clog2(N) (minimum 1), row/column address width

Ports:
- clk  input  1  single system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- valid  input  1  sample strobe; data accepted on any rising clk edge with valid=1
- data  input  DW  sample value (unsigned, stored verbatim)
- rd_row  input  AW  element row index i
- rd_col  input  AW  element column index j
- rd_data  output  DW  registered element T[i][j]
- mat_valid  output  1  window fully populated, matrix contents meaningful
- mat_update  output  1  one-cycle pulse: matrix changed while mat_valid
- sample_cnt  output  AW+2  accepted samples, saturating at window depth W

Behaviour:
- Window depth W = 2N-1 registers w[0..W-1]; w[W-1] is newest, w[0] is oldest.
- On clk edge with valid=1 (and rst=0): w[k] <= w[k+1] for k < W-1, and w[W-1] <= data. With valid=0 the window holds; there is no backpressure, so every valid cycle is accepted.
- Element mapping: T[i][j] = w[N-1+i-j].
  - T[N-1][0] = newest, T[0][N-1] = oldest.
  - Main diagonal = w[N-1].
  - Every diagonal is constant (Toeplitz).
- rd_data: registered with 1-cycle latency; rd_data <= T[rd_row][rd_col] on every edge, independent of valid. An index >= N returns 0.
- Simultaneous write and read: the read returns the pre-shift window, because the old register values are sampled on the same edge.
- sample_cnt increments per accepted sample and saturates at W.
- mat_valid <= 1 on the edge that accepts the W-th sample and stays high until reset.
- mat_update <= 1 for exactly the cycle after any accepted sample, provided mat_valid is (or becomes) 1 on that edge; otherwise 0.
- Reset: all window registers, rd_data, sample_cnt, mat_valid and mat_update go to 0 on the next edge.
  - Reset has priority over valid.
  - Reset mid-stream discards partial and full windows; refill requires W fresh samples.
- Bursts of any length are supported. After the burst ends (valid falls), the matrix is frozen and stays readable indefinitely.

Optional Feature:
- Macro MATRIX_SYMM_EN.
- Defined: symmetric Toeplitz mode.
  - Window depth W = N; w[0] is the oldest of the last N samples.
  - T[i][j] = w[|i-j|].
  - mat_valid asserts after N samples; sample_cnt saturates at N.
- Undefined: general Toeplitz mode as described above (W = 2N-1).

Test Plan:
- Reset then idle -> rd_data=0, mat_valid=0, sample_cnt=0 for all addresses.
- N=4, feed samples 1..6 -> mat_valid stays 0, sample_cnt=6. 7th sample (7) -> mat_valid=1 on that edge, mat_update pulse next cycle, T[3][0]=7, T[0][3]=1, T[i][i]=4.
- Continuous burst of 1..21, then valid=0 for 40 cycles -> matrix frozen: T[3][0]=21, T[0][3]=15, diagonal=18, T[1][0]=T[2][1]=T[3][2]=19. No mat_update while idle.
- Read T[2][0] on the same edge that sample 22 is accepted -> returns 20 (pre-shift value); next read returns 21.
- rst asserted mid-burst together with valid=1 -> data ignored, all outputs 0; 7 new samples are needed before mat_valid returns.
- MATRIX_SYMM_EN, N=4, samples 1..5 -> w=2,3,4,5; T[0][0]=2, T[0][3]=T[3][0]=5, T[1][2]=3.
